// File: rtl/tick_gen_pkg.sv
// rtl/tick_gen_pkg.sv - shared constants and state type for the tick rate generator
package tick_gen_pkg;

   // Two-state control: parked, or generating ticks
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Divide value in force after reset
   localparam int DEFAULT_DIV = 1000;

endpackage

// File: rtl/tick_div_shadow.sv
// rtl/tick_div_shadow.sv - divide-value shadow register with load handshake and boundary apply
module tick_div_shadow #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] div_in,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             running,
   input  logic             boundary,
   input  logic             leave,
   output logic [WIDTH-1:0] div_act
);

   logic             pending;
   logic [WIDTH-1:0] shadow;
   logic             accept;

   // One shadow slot: a new value is taken only while nothing is waiting to be applied
   assign div_ready = ~pending;
   assign accept    = div_valid & ~pending;

   // Loads go straight to the active divide when parked; while running they wait for the
   // period boundary so the period in progress keeps its length. Leaving RUN flushes the slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_act <= WIDTH'(DEFAULT_DIV);
         shadow  <= '0;
         pending <= 1'b0;
      end else if (!running) begin
         if (accept) begin
            div_act <= div_in;
         end
      end else if (leave) begin
         if (accept) begin
            div_act <= div_in;
         end else if (pending) begin
            div_act <= shadow;
         end
         pending <= 1'b0;
      end else if (boundary && pending) begin
         div_act <= shadow;
         pending <= 1'b0;
      end else if (accept) begin
         shadow  <= div_in;
         pending <= 1'b1;
      end
   end

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable tick rate generator with burst and start/stop control
module tick_gen #(
   parameter int WIDTH       = 16,
   parameter int BURST_W     = 8,
   parameter int DEFAULT_DIV = tick_gen_pkg::DEFAULT_DIV
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   div_in,
   input  logic               div_valid,
   output logic               div_ready,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               start,
   input  logic               stop,
   output logic               tick,
   output logic               busy,
   output logic               done
);

   import tick_gen_pkg::*;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   div_act;
   logic [WIDTH-1:0]   div_eff;
   logic [WIDTH-1:0]   pcnt;
   logic [BURST_W-1:0] bcnt;
   logic [BURST_W-1:0] blen;
   logic               running;
   logic               at_end;
   logic               last_tick;
   logic               boundary;
   logic               leave;
   logic               launch;

   // A divide of zero behaves as one so the prescaler always has a reachable terminal count
   assign div_eff   = (div_act == '0) ? WIDTH'(1) : div_act;
   assign running   = (state == RUN);
   assign at_end    = (pcnt == (div_eff - WIDTH'(1)));
   assign last_tick = (blen != '0) &&
                      (({1'b0, bcnt} + (BURST_W+1)'(1)) == {1'b0, blen});
   assign launch    = (state == IDLE) && start && !stop;
   // Stop outranks a tick due on the same edge, so the boundary is suppressed then
   assign boundary  = running && !stop && at_end;
   assign leave     = running && (stop || (at_end && last_tick));

   tick_div_shadow #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .running   (running),
      .boundary  (boundary),
      .leave     (leave),
      .div_act   (div_act)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: start from IDLE, leave RUN on stop or on the final tick of a burst
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (at_end && last_tick) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state == RUN);
   end

   // Prescaler, burst counter and registered tick/done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
         bcnt <= '0;
         blen <= '0;
         tick <= 1'b0;
         done <= 1'b0;
      end else if (!running) begin
         tick <= 1'b0;
         done <= 1'b0;
         if (launch) begin
            pcnt <= '0;
            bcnt <= '0;
            blen <= burst_len;
         end
      end else if (stop) begin
         pcnt <= '0;
         tick <= 1'b0;
         done <= 1'b0;
      end else if (at_end) begin
         pcnt <= '0;
         tick <= 1'b1;
         done <= last_tick;
         if ((blen != '0) && (bcnt != '1)) begin
            bcnt <= bcnt + BURST_W'(1);
         end
      end else begin
         pcnt <= pcnt + WIDTH'(1);
         tick <= 1'b0;
         done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen
module tb_tick_gen;

   localparam int WIDTH   = 16;
   localparam int BURST_W = 8;
   localparam int DEF_DIV = tick_gen_pkg::DEFAULT_DIV;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [WIDTH-1:0]   div_in = '0;
   logic               div_valid = 1'b0;
   logic               div_ready;
   logic [BURST_W-1:0] burst_len = '0;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               tick;
   logic               busy;
   logic               done;

   tick_gen #(
      .WIDTH   (WIDTH),
      .BURST_W (BURST_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .div_in    (div_in),
      .div_valid (div_valid),
      .div_ready (div_ready),
      .burst_len (burst_len),
      .start     (start),
      .stop      (stop),
      .tick      (tick),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit last;
   } exp_t;

   typedef struct {
      int div;
      int burst;
      int cycles;
      int period;
      int ticks;
   } vec_t;

   exp_t q[$];
   vec_t tbl[5];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   tick_seen = 0;
   int   c0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      bit et;
      bit ed;
      @(posedge clk);
      #1;
      cyc++;
      et = (q.size() > 0) && (q[0].cyc == cyc);
      ed = et && q[0].last;
      check("tick", 32'(tick), 32'(et));
      check("done", 32'(done), 32'(ed));
      if (tick === 1'b1) tick_seen++;
      if (et) void'(q.pop_front());
   endtask

   task automatic push_ticks(input int base, input int period, input int n, input int burst);
      for (int k = 1; k <= n; k++) begin
         q.push_back('{cyc: base + k * period, last: (burst != 0) && (k == n)});
      end
   endtask

   task automatic load_div(input int v);
      div_in = WIDTH'(v);
      div_valid = 1'b1;
      step();
      div_valid = 1'b0;
   endtask

   task automatic start_run(input int b, output int base);
      burst_len = BURST_W'(b);
      start = 1'b1;
      step();
      start = 1'b0;
      base = cyc;
   endtask

   task automatic stop_run();
      q.delete();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("busy_after_stop", 32'(busy), 32'd0);
   endtask

   initial begin
      int cnt8;
      int ov_at;
      int nt;

      tbl[0] = '{div: 4, burst: 0, cycles: 41, period: 4, ticks: 10};
      tbl[1] = '{div: 3, burst: 5, cycles: 25, period: 3, ticks: 5};
      tbl[2] = '{div: 0, burst: 3, cycles: 10, period: 1, ticks: 3};
      tbl[3] = '{div: 2, burst: 1, cycles: 10, period: 2, ticks: 1};
      tbl[4] = '{div: 7, burst: 2, cycles: 20, period: 7, ticks: 2};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_div_ready", 32'(div_ready), 32'd1);
      rst = 1'b1;
      step();

      // table-driven runs
      for (int i = 0; i < 5; i++) begin
         load_div(tbl[i].div);
         check("idle_div_ready", 32'(div_ready), 32'd1);
         tick_seen = 0;
         start_run(tbl[i].burst, c0);
         check("busy_run", 32'(busy), 32'd1);
         push_ticks(c0, tbl[i].period,
                    (tbl[i].burst != 0) ? tbl[i].burst : tbl[i].cycles / tbl[i].period,
                    tbl[i].burst);
         repeat (tbl[i].cycles) step();
         check("tick_count", 32'(tick_seen), 32'(tbl[i].ticks));
         if (tbl[i].burst != 0) begin
            check("busy_after_burst", 32'(busy), 32'd0);
            check("burst_queue_empty", 32'(q.size()), 32'd0);
         end else begin
            check("busy_cont", 32'(busy), 32'd1);
            stop_run();
         end
         repeat (2) step();
      end

      // start while running is ignored; burst length is not re-sampled
      load_div(3);
      tick_seen = 0;
      start_run(5, c0);
      push_ticks(c0, 3, 5, 5);
      repeat (2) step();
      burst_len = BURST_W'(2);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (16) step();
      check("restart_ignored_ticks", 32'(tick_seen), 32'd5);
      check("restart_ignored_busy", 32'(busy), 32'd0);

      // divide change mid-period takes effect at the next boundary
      load_div(10);
      start_run(0, c0);
      push_ticks(c0, 10, 1, 0);
      repeat (3) step();
      div_in = WIDTH'(2);
      div_valid = 1'b1;
      step();
      check("ready_drop", 32'(div_ready), 32'd0);
      div_in = WIDTH'(7);
      repeat (4) step();
      check("ready_held_low", 32'(div_ready), 32'd0);
      div_valid = 1'b0;
      step();
      check("ready_before_boundary", 32'(div_ready), 32'd0);
      push_ticks(c0 + 10, 2, 5, 0);
      step();
      check("ready_at_boundary", 32'(div_ready), 32'd1);
      repeat (11) step();
      stop_run();
      step();

      // stop on the edge a tick is due
      load_div(3);
      start_run(0, c0);
      push_ticks(c0, 3, 1, 0);
      repeat (5) step();
      stop_run();
      step();
      check("stop_idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      check("start_stop_busy", 32'(busy), 32'd0);
      step();
      check("start_stop_busy2", 32'(busy), 32'd0);

      // divide of zero gives continuous ticks; 8-bit counter downstream overflows at tick 256
      load_div(0);
      start_run(0, c0);
      push_ticks(c0, 1, 260, 0);
      cnt8 = 0;
      ov_at = 0;
      nt = 0;
      for (int k = 0; k < 260; k++) begin
         step();
         if (tick === 1'b1) begin
            nt++;
            if (cnt8 == 255 && ov_at == 0) ov_at = nt;
            cnt8 = (cnt8 + 1) & 255;
         end
      end
      check("overflow_tick", 32'(ov_at), 32'd256);
      check("busy_d1", 32'(busy), 32'd1);
      stop_run();
      step();

      // asynchronous reset mid-burst
      load_div(4);
      start_run(8, c0);
      push_ticks(c0, 4, 8, 8);
      repeat (12) step();
      check("pre_reset_tick", 32'(tick), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_done", 32'(done), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b1;
      step();
      check("post_rst_div_ready", 32'(div_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);
      tick_seen = 0;
      start_run(1, c0);
      push_ticks(c0, DEF_DIV, 1, 1);
      repeat (DEF_DIV) step();
      check("default_div_ticks", 32'(tick_seen), 32'd1);
      check("default_div_busy", 32'(busy), 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
